calc_controller: RTL and testbench

//  Sequences the two-operand calculator datapath: turns raw board push-buttons into the 3-bit

---
 rtl/calc_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 62 ++++++
 rtl/calc_controller.sv | 157 +++++++++++++++
 tb/tb_calc_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: constants shared by the calculator controller and the result
// selector. The state encoding is what the display/result selector decodes
// directly, so the numeric values are part of the board-level interface.
package calc_pkg;

  localparam int OPERAND_W = 7;

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_SOMA = 3'd1,
    ST_SUB  = 3'd2,
    ST_MULT = 3'd3,
    ST_ON   = 3'd4
  } calc_state_e;

  // Unsigned saturation of a switch value to the two-digit display range.
  function automatic logic [OPERAND_W-1:0] clamp_operand(
    input logic [OPERAND_W-1:0] value,
    input logic [OPERAND_W-1:0] max_value
  );
    return (value > max_value) ? max_value : value;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: conditions one raw, asynchronous push-button.
//   A 2-flop synchronizer feeds a debouncer that tracks a debounced level.
//   When the synchronized level differs from the debounced level for
//   DEBOUNCE_CYCLES consecutive cycles the debounced level flips; a 0->1 flip
//   produces a single-cycle press pulse (registered). Any glitch back to the
//   debounced level restarts the count, so a held button gives one pulse and
//   a new press first needs a debounced release.
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    asynchronous active-high reset (clears sync, count and pulse)
//   btn_i    raw button level, asynchronous to clk_i
//   press_o  one-cycle press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // The count only advances while the synchronized level disagrees with the
  // debounced level; the cycle that completes the run flips the level instead
  // of incrementing, so the counter never needs to reach DEBOUNCE_CYCLES.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/calc_controller.sv
// calc_controller: sequences the two-operand calculator datapath.
//   Debounces the power/op/load buttons, runs the operating-state FSM,
//   holds the two operands loaded alternately from the switch bank, and
//   forces Off after IDLE_TIMEOUT cycles without a press (0 disables it).
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   btn_power    raw power button, active-high
//   btn_op       raw operation-select button, active-high
//   btn_load     raw operand-load button, active-high
//   sw_value     operand value from the switches
//   estado       operating state (calc_state_e encoding), registered
//   n1, n2       operand registers
//   operand_sel  0: next load targets n1, 1: next load targets n2
//   idle_off     one-cycle pulse when the idle timer forces Off
module calc_controller
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int IDLE_TIMEOUT    = 1024,
  parameter int OPERAND_MAX     = 99
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_power,
  input  logic                 btn_op,
  input  logic                 btn_load,
  input  logic [OPERAND_W-1:0] sw_value,
  output logic [2:0]           estado,
  output logic [OPERAND_W-1:0] n1,
  output logic [OPERAND_W-1:0] n2,
  output logic                 operand_sel,
  output logic                 idle_off
);

  logic pwr_pulse, op_pulse, load_pulse;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_power (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_power),
    .press_o (pwr_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_op (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_op),
    .press_o (op_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_load),
    .press_o (load_pulse)
  );

  calc_state_e          state_q, state_d;
  logic [OPERAND_W-1:0] n1_q, n1_d;
  logic [OPERAND_W-1:0] n2_q, n2_d;
  logic                 sel_q, sel_d;
  logic                 idle_off_q, idle_off_d;
  logic                 accept;
  logic                 idle_hit;
  logic [OPERAND_W-1:0] load_value;

  // op/load are only meaningful once powered; power is always accepted.
  assign accept     = pwr_pulse | ((op_pulse | load_pulse) & (state_q != ST_OFF));
  assign load_value = clamp_operand(sw_value, OPERAND_W'(OPERAND_MAX));

  generate
    if (IDLE_TIMEOUT > 0) begin : g_idle
      localparam int IW = $clog2(IDLE_TIMEOUT + 1);
      logic [IW-1:0] timer_q, timer_d;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
      end

      always_comb begin
        timer_d = timer_q + 1'b1;
        if ((state_q == ST_OFF) || accept || idle_hit) timer_d = '0;
      end

      assign idle_hit = (state_q != ST_OFF) && (timer_q == IW'(IDLE_TIMEOUT - 1));
    end else begin : g_no_idle
      assign idle_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_OFF;
      n1_q       <= '0;
      n2_q       <= '0;
      sel_q      <= 1'b0;
      idle_off_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n1_q       <= n1_d;
      n2_q       <= n2_d;
      sel_q      <= sel_d;
      idle_off_q <= idle_off_d;
    end
  end

  // Priority per cycle: power over everything; op and load combine; the idle
  // expiry only takes effect when no pulse arrived in the terminal cycle.
  always_comb begin
    state_d    = state_q;
    n1_d       = n1_q;
    n2_d       = n2_q;
    sel_d      = sel_q;
    idle_off_d = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (pwr_pulse) begin
          state_d = ST_ON;
          n1_d    = '0;
          n2_d    = '0;
          sel_d   = 1'b0;
        end
      end
      ST_ON, ST_SOMA, ST_SUB, ST_MULT: begin
        if (pwr_pulse) begin
          state_d = ST_OFF;
        end else if (op_pulse || load_pulse) begin
          if (op_pulse) begin
            case (state_q)
              ST_SOMA: state_d = ST_SUB;
              ST_SUB:  state_d = ST_MULT;
              default: state_d = ST_SOMA;
            endcase
          end
          if (load_pulse) begin
            if (!sel_q) n1_d = load_value;
            else        n2_d = load_value;
            sel_d = ~sel_q;
          end
        end else if (idle_hit) begin
          state_d    = ST_OFF;
          idle_off_d = 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  assign estado      = state_q;
  assign n1          = n1_q;
  assign n2          = n2_q;
  assign operand_sel = sel_q;
  assign idle_off    = idle_off_q;

endmodule

// File: tb/tb_calc_controller.sv
module tb_calc_controller;

  localparam int D = 8;
  localparam int T = 300;
  localparam int OMAX = 99;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn = '0;          // [0] power, [1] op, [2] load
  logic [6:0] sw  = '0;
  logic [2:0] estado;
  logic [6:0] n1, n2;
  logic       operand_sel, idle_off;

  int n_vec = 0;
  int n_err = 0;
  int idle_seen = 0;

  calc_controller #(
    .DEBOUNCE_CYCLES (D),
    .IDLE_TIMEOUT    (T),
    .OPERAND_MAX     (OMAX)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .btn_power   (btn[0]),
    .btn_op      (btn[1]),
    .btn_load    (btn[2]),
    .sw_value    (sw),
    .estado      (estado),
    .n1          (n1),
    .n2          (n2),
    .operand_sel (operand_sel),
    .idle_off    (idle_off)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: a button registers a press when its raw level,
  // seen two clocks late, has read 1 for the last D clocks while the button
  // was considered released (release is the mirror with 0s). The press acts
  // on the calculator one clock later.
  logic [63:0] sh [3];
  bit lvl  [3];
  bit pend [3];
  int m_state, m_n1, m_n2, m_sel, m_idle_off, m_idle_cnt;

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      sh[b] = '0; lvl[b] = 0; pend[b] = 0;
    end
    m_state = 0; m_n1 = 0; m_n2 = 0; m_sel = 0; m_idle_off = 0; m_idle_cnt = 0;
  endtask

  task automatic model_step();
    int ones;
    int v;
    m_idle_off = 0;
    if (m_state == 0) begin
      if (pend[0]) begin
        m_state = 4; m_n1 = 0; m_n2 = 0; m_sel = 0;
      end
      m_idle_cnt = 0;
    end else if (pend[0]) begin
      m_state = 0; m_idle_cnt = 0;
    end else if (pend[1] || pend[2]) begin
      if (pend[1]) m_state = (m_state == 4 || m_state == 3) ? 1 : m_state + 1;
      if (pend[2]) begin
        v = (int'(sw) > OMAX) ? OMAX : int'(sw);
        if (m_sel == 0) m_n1 = v; else m_n2 = v;
        m_sel = 1 - m_sel;
      end
      m_idle_cnt = 0;
    end else if (m_idle_cnt == T - 1) begin
      m_state = 0; m_idle_off = 1; m_idle_cnt = 0;
    end else begin
      m_idle_cnt++;
    end
    for (int b = 0; b < 3; b++) begin
      ones = 0;
      for (int k = 1; k <= D; k++) ones += int'(sh[b][k]);
      pend[b] = 0;
      if (!lvl[b] && ones == D) begin
        lvl[b] = 1; pend[b] = 1;
      end else if (lvl[b] && ones == 0) begin
        lvl[b] = 0;
      end
      sh[b] = {sh[b][62:0], btn[b]};
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check_val("estado", int'(estado), m_state);
      check_val("n1", int'(n1), m_n1);
      check_val("n2", int'(n2), m_n2);
      check_val("operand_sel", int'(operand_sel), m_sel);
      check_val("idle_off", int'(idle_off), m_idle_off);
      if (idle_off) idle_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] mask, input int hold);
    btn = mask;
    tick(hold);
    btn = '0;
    tick(D + 4);
  endtask

  initial begin
    int idle0;
    logic [2:0] mask;
    int hold, gap;

    // 1: reset, then one long power press
    tick(3);
    rst = 1'b0;
    check_val("rst_estado", int'(estado), 0);
    check_val("rst_n1", int'(n1), 0);
    check_val("rst_sel", int'(operand_sel), 0);
    press(3'b001, 40);
    check_val("pwr_on_estado", int'(estado), 4);
    check_val("pwr_on_n2", int'(n2), 0);

    // 2: alternate loads with clamp, then cycle ops
    sw = 7'd37;  press(3'b100, 20);
    sw = 7'd120; press(3'b100, 20);
    check_val("load_n1", int'(n1), 37);
    check_val("load_n2_clamp", int'(n2), 99);
    check_val("load_sel_back", int'(operand_sel), 0);
    press(3'b010, 20); check_val("op1", int'(estado), 1);
    press(3'b010, 20); check_val("op2", int'(estado), 2);
    press(3'b010, 20); check_val("op3", int'(estado), 3);
    press(3'b010, 20); check_val("op4_wrap", int'(estado), 1);

    // 3: bouncing op press, one pulse timed from the last edge
    for (int i = 0; i < 6; i++) begin
      btn[1] = (i % 2 == 0);
      tick(3);
    end
    check_val("bounce_hold", int'(estado), 1);
    btn[1] = 1'b1;
    tick(D + 2);
    check_val("bounce_pre", int'(estado), 1);
    tick(1);
    check_val("bounce_post", int'(estado), 2);
    btn[1] = 1'b0;
    tick(D + 4);

    // 4: power wins over load; op+load combine
    press(3'b010, 20); check_val("to_mult", int'(estado), 3);
    sw = 7'd5;
    press(3'b101, 20);
    check_val("pwr_load_estado", int'(estado), 0);
    check_val("pwr_load_n1", int'(n1), 37);
    check_val("pwr_load_n2", int'(n2), 99);
    press(3'b001, 20);
    press(3'b010, 20); check_val("soma", int'(estado), 1);
    sw = 7'd55;
    press(3'b110, 20);
    check_val("op_load_estado", int'(estado), 2);
    check_val("op_load_n1", int'(n1), 55);
    check_val("op_load_sel", int'(operand_sel), 1);

    // 5: idle expiry, then a load landing in the terminal cycle
    idle0 = idle_seen;
    tick(T + 50);
    check_val("idle_pulses", idle_seen - idle0, 1);
    check_val("idle_estado", int'(estado), 0);
    check_val("idle_n1_held", int'(n1), 55);
    idle0 = idle_seen;
    btn[0] = 1'b1; tick(20); btn[0] = 1'b0;
    tick(T - 20);
    sw = 7'd11;
    press(3'b100, 20);
    check_val("idle_save_estado", int'(estado), 4);
    check_val("idle_save_n1", int'(n1), 11);
    check_val("idle_save_pulses", idle_seen - idle0, 0);

    // 6: reset mid-debounce in Sub
    press(3'b010, 20);
    press(3'b010, 20);
    check_val("to_sub", int'(estado), 2);
    btn[1] = 1'b1;
    tick(D / 2 + 2);
    #2 rst = 1'b1;
    #1;
    check_val("midrst_estado", int'(estado), 0);
    check_val("midrst_n1", int'(n1), 0);
    check_val("midrst_n2", int'(n2), 0);
    check_val("midrst_sel", int'(operand_sel), 0);
    check_val("midrst_idle", int'(idle_off), 0);
    btn[1] = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3 * D);
    check_val("post_rst_estado", int'(estado), 0);

    // Randomized phase against the reference model
    for (int s = 0; s < 120; s++) begin
      sw = 7'($urandom_range(0, 127));
      mask = 3'($urandom_range(0, 7));
      if (mask[0] && $urandom_range(0, 3) != 0) mask[0] = 1'b0;
      hold = $urandom_range(1, 3 * D);
      btn = mask;
      tick(hold);
      btn = '0;
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 20, T + 20)
                                        : $urandom_range(1, 2 * D);
      tick(gap);
    end
    tick(2 * D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
